idli_sqi_mem_m: RTL



---
 rtl/idli_pkg.sv | 32 +++
 rtl/idli_sqi_mem_array_m.sv | 26 ++
 rtl/idli_sqi_mem_m.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli core and its SQI memory responder.
// The responder's mode register only exists when IDLI_SQI_MEM_MODE_REG_EN is defined.
package idli_pkg;

    // Direction of the core's sio pins.
    localparam logic [1:0] SQI_IO_MODE_OUT = 2'd0;
    localparam logic [1:0] SQI_IO_MODE_IN  = 2'd1;

    typedef enum logic [7:0] {
        SQI_CMD_WRMR  = 8'h01,
        SQI_CMD_WRITE = 8'h02,
        SQI_CMD_READ  = 8'h03,
        SQI_CMD_RDMR  = 8'h05
    } sqi_cmd_t;

    typedef enum logic [2:0] {
        SQI_MEM_IDLE,
        SQI_MEM_CMD,
        SQI_MEM_ADDR,
        SQI_MEM_DUMMY,
        SQI_MEM_RD_DATA,
        SQI_MEM_WR_DATA,
        SQI_MEM_IGNORE
    } sqi_mem_state_t;

    // Access type held in mode[7:6]; 2'b11 behaves as sequential.
    localparam logic [1:0] SQI_MODE_BYTE  = 2'b00;
    localparam logic [1:0] SQI_MODE_SEQ   = 2'b01;
    localparam logic [1:0] SQI_MODE_PAGE  = 2'b10;
    localparam logic [7:0] SQI_MODE_RESET = 8'h40;

endpackage

// File: rtl/idli_sqi_mem_array_m.sv
// Byte array behind the SQI responder: one synchronous write port and one
// asynchronous read port sharing a single address. Contents are not reset.
module idli_sqi_mem_array_m
    import idli_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];

    // Write the byte at the current address when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI (quad-SPI) SRAM responder. SCK is oversampled on i_mem_gck: nibbles are
// taken on SCK rise, the response nibble and oe are updated on SCK fall.
// Optional mode register (RDMR/WRMR, byte/page/sequential access) is built
// when IDLI_SQI_MEM_MODE_REG_EN is defined.
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    localparam int ADDR_NIB = ADDR_W / 4;

    sqi_mem_state_t    r_state, w_state_nxt;
    logic              r_sck_q;
    logic              w_rise, w_fall;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [3:0]        r_wbuf, w_wbuf_nxt;   // first nibble of a cmd/data byte
    logic              r_lo, w_lo_nxt;       // next nibble is the low one
    logic              r_rd, w_rd_nxt;
    logic [3:0]        r_sio, w_sio_nxt;
    logic              r_oe, w_oe_nxt;
    logic              w_we;
    logic [7:0]        w_byte, w_mem_rdata, w_rd_byte;
    logic [1:0]        w_acc;
    logic              w_rdmr, w_wrmr;

`ifdef IDLI_SQI_MEM_MODE_REG_EN
    logic [7:0] r_mode, w_mode_nxt;
    logic       r_rdmr, w_rdmr_nxt;
    logic       r_wrmr, w_wrmr_nxt;
    assign w_acc     = r_mode[7:6];
    assign w_rdmr    = r_rdmr;
    assign w_wrmr    = r_wrmr;
    assign w_rd_byte = r_rdmr ? r_mode : w_mem_rdata;
`else
    assign w_acc     = SQI_MODE_SEQ;
    assign w_rdmr    = 1'b0;
    assign w_wrmr    = 1'b0;
    assign w_rd_byte = w_mem_rdata;
`endif

    assign w_rise = i_mem_sck & ~r_sck_q;
    assign w_fall = ~i_mem_sck & r_sck_q;
    assign w_byte = {r_wbuf, i_mem_sio};

    assign o_mem_sio    = r_sio;
    assign o_mem_sio_oe = r_oe;

    // Page access keeps the upper bits and wraps within 32 bytes.
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                      input logic [1:0] acc);
        logic [ADDR_W-1:0] inc;
        inc = a + 1'b1;
        if (acc == SQI_MODE_PAGE) begin
            return {a[ADDR_W-1:5], inc[4:0]};
        end
        return inc;
    endfunction

    idli_sqi_mem_array_m #(.ADDR_W(ADDR_W)) u_array (
        .i_clk   (i_mem_gck),
        .i_we    (w_we),
        .i_addr  (r_addr),
        .i_wdata (w_byte),
        .o_rdata (w_mem_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            r_state <= SQI_MEM_IDLE;
            r_sck_q <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_wbuf  <= '0;
            r_lo    <= 1'b0;
            r_rd    <= 1'b0;
            r_sio   <= '0;
            r_oe    <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
            r_mode  <= SQI_MODE_RESET;
            r_rdmr  <= 1'b0;
            r_wrmr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sck_q <= i_mem_sck;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wbuf  <= w_wbuf_nxt;
            r_lo    <= w_lo_nxt;
            r_rd    <= w_rd_nxt;
            r_sio   <= w_sio_nxt;
            r_oe    <= w_oe_nxt;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
            r_mode  <= w_mode_nxt;
            r_rdmr  <= w_rdmr_nxt;
            r_wrmr  <= w_wrmr_nxt;
`endif
        end
    end

    // Protocol decode: cs high aborts everything and masks any SCK edge.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_wbuf_nxt  = r_wbuf;
        w_lo_nxt    = r_lo;
        w_rd_nxt    = r_rd;
        w_sio_nxt   = r_sio;
        w_oe_nxt    = r_oe;
        w_we        = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
        w_mode_nxt  = r_mode;
        w_rdmr_nxt  = r_rdmr;
        w_wrmr_nxt  = r_wrmr;
`endif
        if (i_mem_cs) begin
            w_state_nxt = SQI_MEM_IDLE;
            w_addr_nxt  = '0;
            w_cnt_nxt   = '0;
            w_lo_nxt    = 1'b0;
            w_rd_nxt    = 1'b0;
            w_sio_nxt   = '0;
            w_oe_nxt    = 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
            w_rdmr_nxt  = 1'b0;
            w_wrmr_nxt  = 1'b0;
`endif
        end else begin
            case (r_state)
                SQI_MEM_IDLE: begin
                    w_state_nxt = SQI_MEM_CMD;
                    w_cnt_nxt   = '0;
                    w_lo_nxt    = 1'b0;
                end
                SQI_MEM_CMD: if (w_rise) begin
                    if (!r_lo) begin
                        w_wbuf_nxt = i_mem_sio;
                        w_lo_nxt   = 1'b1;
                    end else begin
                        w_lo_nxt  = 1'b0;
                        w_cnt_nxt = '0;
                        case (w_byte)
                            SQI_CMD_READ: begin
                                w_state_nxt = SQI_MEM_ADDR;
                                w_rd_nxt    = 1'b1;
                            end
                            SQI_CMD_WRITE: begin
                                w_state_nxt = SQI_MEM_ADDR;
                                w_rd_nxt    = 1'b0;
                            end
`ifdef IDLI_SQI_MEM_MODE_REG_EN
                            SQI_CMD_RDMR: begin
                                w_state_nxt = SQI_MEM_DUMMY;
                                w_rd_nxt    = 1'b1;
                                w_rdmr_nxt  = 1'b1;
                            end
                            SQI_CMD_WRMR: begin
                                w_state_nxt = SQI_MEM_WR_DATA;
                                w_wrmr_nxt  = 1'b1;
                            end
`endif
                            default: w_state_nxt = SQI_MEM_IGNORE;
                        endcase
                    end
                end
                SQI_MEM_ADDR: if (w_rise) begin
                    w_addr_nxt = {r_addr[ADDR_W-5:0], i_mem_sio};
                    w_cnt_nxt  = r_cnt + 8'd1;
                    if (r_cnt == 8'(ADDR_NIB - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_rd ? SQI_MEM_DUMMY : SQI_MEM_WR_DATA;
                    end
                end
                SQI_MEM_DUMMY: begin
                    if (w_rise) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end else if (w_fall && r_cnt == 8'(DUMMY_NIBBLES)) begin
                        w_oe_nxt    = 1'b1;
                        w_sio_nxt   = w_rd_byte[7:4];
                        w_lo_nxt    = 1'b1;
                        w_state_nxt = SQI_MEM_RD_DATA;
                    end
                end
                SQI_MEM_RD_DATA: if (w_fall) begin
                    if (r_lo) begin
                        w_sio_nxt = w_rd_byte[3:0];
                        w_lo_nxt  = 1'b0;
                        if (!w_rdmr) begin
                            w_addr_nxt = f_next_addr(r_addr, w_acc);
                        end
                    end else if (w_acc == SQI_MODE_BYTE && !w_rdmr) begin
                        // The low nibble stays on the bus until this fall.
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = SQI_MEM_IGNORE;
                    end else begin
                        w_sio_nxt = w_rd_byte[7:4];
                        w_lo_nxt  = 1'b1;
                    end
                end
                SQI_MEM_WR_DATA: if (w_rise) begin
                    if (!r_lo) begin
                        w_wbuf_nxt = i_mem_sio;
                        w_lo_nxt   = 1'b1;
                    end else begin
                        w_lo_nxt = 1'b0;
                        if (w_wrmr) begin
`ifdef IDLI_SQI_MEM_MODE_REG_EN
                            w_mode_nxt = w_byte;
`endif
                            w_state_nxt = SQI_MEM_IGNORE;
                        end else begin
                            w_we       = 1'b1;
                            w_addr_nxt = f_next_addr(r_addr, w_acc);
                            if (w_acc == SQI_MODE_BYTE) begin
                                w_state_nxt = SQI_MEM_IGNORE;
                            end
                        end
                    end
                end
                SQI_MEM_IGNORE: ;
                default: w_state_nxt = SQI_MEM_IDLE;
            endcase
        end
    end

endmodule
